// File: rtl/decoder_viterbi.sv
// Hard-decision Viterbi decoder for the 8-state recursive systematic code
// fb = u^s1^s0, sys = u, par = fb^s2^s0, next = {fb,s2,s1}, start state 000.
// One block of BLOCK_LEN symbols is collected with add-compare-select, the
// best end state is picked, and a traceback produces the decoded bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any block in progress
//   in_valid   a received symbol is present on sys_bit/par_bit
//   sys_bit    received systematic bit
//   par_bit    received parity bit
//   in_ready   decoder accepts a symbol this cycle (ACS phase only)
//   out_valid  one-cycle pulse, out_block/out_metric carry a new result
//   out_block  decoded bits, bit 0 = first symbol of the block
//   out_metric Hamming distance of the winning path
module decoder_viterbi #(
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned PM_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 sys_bit,
  input  logic                 par_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [BLOCK_LEN-1:0] out_block,
  output logic [PM_W-1:0]      out_metric
);

  localparam int unsigned CntW = $clog2(BLOCK_LEN + 1);
  localparam int unsigned IdxW = $clog2(BLOCK_LEN);
  localparam logic [PM_W-1:0] PmInit = PM_W'(64);

  localparam logic [1:0] StAcs    = 2'd0;
  localparam logic [1:0] StSelect = 2'd1;
  localparam logic [1:0] StTrace  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]                state_q, state_d;
  // Symbol count during ACS, traceback index during TRACE.
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [7:0][PM_W-1:0]      pm_q, pm_d;
  logic [7:0][PM_W-1:0]      acs_pm;
  logic [7:0]                acs_dec;
  logic [7:0]                dec_mem_q [BLOCK_LEN];
  logic [2:0]                tb_state_q, tb_state_d;
  logic [PM_W-1:0]           best_pm_q, best_pm_d;
  logic [BLOCK_LEN-1:0]      bits_q, bits_d;
  logic [BLOCK_LEN-1:0]      out_block_q, out_block_d;
  logic [PM_W-1:0]           out_metric_q, out_metric_d;
  logic [2:0]                min_idx;
  logic [PM_W-1:0]           min_val;
  logic [7:0]                dec_word;
  logic                      tb_dec;
  logic                      tb_bit;
  logic                      accept;

  function automatic logic [1:0] branch_metric(input logic rx_sys, input logic rx_par,
                                               input logic exp_sys, input logic exp_par);
    return 2'(rx_sys != exp_sys) + 2'(rx_par != exp_par);
  endfunction

  assign in_ready   = (state_q == StAcs) && !rst;
  assign out_valid  = (state_q == StDone) && !rst;
  assign out_block  = out_block_q;
  assign out_metric = out_metric_q;
  assign accept     = in_valid && in_ready;

  // Add-compare-select. For next state n the predecessor is {n[1],n[0],d};
  // the branch input is n[2]^n[0]^d and the branch parity n[2]^n[1]^d.
  always_comb begin
    acs_pm  = '0;
    acs_dec = '0;
    for (int n = 0; n < 8; n++) begin
      logic [PM_W-1:0] cand0;
      logic [PM_W-1:0] cand1;
      cand0 = pm_q[{n[1], n[0], 1'b0}]
            + PM_W'(branch_metric(sys_bit, par_bit, n[2] ^ n[0], n[2] ^ n[1]));
      cand1 = pm_q[{n[1], n[0], 1'b1}]
            + PM_W'(branch_metric(sys_bit, par_bit, ~(n[2] ^ n[0]), ~(n[2] ^ n[1])));
      // Strict compare: a tie keeps the s0=0 predecessor.
      acs_dec[n] = (cand1 < cand0);
      acs_pm[n]  = acs_dec[n] ? cand1 : cand0;
    end
  end

  // Lowest-metric end state; strict compare keeps the lowest index on a tie.
  always_comb begin
    min_idx = 3'd0;
    min_val = pm_q[0];
    for (int n = 1; n < 8; n++) begin
      if (pm_q[n] < min_val) begin
        min_idx = 3'(n);
        min_val = pm_q[n];
      end
    end
  end

  assign dec_word = dec_mem_q[cnt_q[IdxW-1:0]];
  assign tb_dec   = dec_word[tb_state_q];
  assign tb_bit   = tb_state_q[2] ^ tb_state_q[0] ^ tb_dec;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pm_d         = pm_q;
    tb_state_d   = tb_state_q;
    best_pm_d    = best_pm_q;
    bits_d       = bits_q;
    out_block_d  = out_block_q;
    out_metric_d = out_metric_q;
    unique case (state_q)
      StAcs: begin
        if (accept) begin
          pm_d  = acs_pm;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(BLOCK_LEN - 1)) begin
            state_d = StSelect;
          end
        end
      end
      StSelect: begin
        tb_state_d = min_idx;
        best_pm_d  = min_val;
        cnt_d      = CntW'(BLOCK_LEN - 1);
        state_d    = StTrace;
      end
      StTrace: begin
        bits_d[cnt_q[IdxW-1:0]] = tb_bit;
        tb_state_d = {tb_state_q[1:0], tb_dec};
        if (cnt_q == '0) begin
          // Outputs load on entry to DONE so they are valid with the pulse.
          out_block_d  = bits_d;
          out_metric_d = best_pm_q;
          state_d      = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        pm_d    = {{7{PmInit}}, PM_W'(0)};
        cnt_d   = '0;
        state_d = StAcs;
      end
      default: state_d = StAcs;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAcs;
      cnt_q        <= '0;
      pm_q         <= {{7{PmInit}}, PM_W'(0)};
      tb_state_q   <= 3'd0;
      best_pm_q    <= '0;
      bits_q       <= '0;
      out_block_q  <= '0;
      out_metric_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pm_q         <= pm_d;
      tb_state_q   <= tb_state_d;
      best_pm_q    <= best_pm_d;
      bits_q       <= bits_d;
      out_block_q  <= out_block_d;
      out_metric_q <= out_metric_d;
    end
  end

  // Survivor decisions need no reset: every entry read in TRACE was written in ACS.
  always_ff @(posedge clk) begin
    if (accept) begin
      dec_mem_q[cnt_q[IdxW-1:0]] <= acs_dec;
    end
  end

endmodule

// File: tb/tb_decoder_viterbi.sv
// Directed bench for decoder_viterbi (BLOCK_LEN=16, PM_W=8): encodes known
// information words with a reference encoder, drives them in, and checks the
// decoded block, metric, latency, in_ready timing and reset aborts.
module tb_decoder_viterbi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sys_bit = 1'b0;
  logic        par_bit = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_block;
  logic [7:0]  out_metric;

  int checks = 0;
  int errors = 0;

  decoder_viterbi #(
    .BLOCK_LEN(16),
    .PM_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sys_bit   (sys_bit),
    .par_bit   (par_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_block (out_block),
    .out_metric(out_metric)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encodes u and drives nsym symbols; gap idle cycles between symbols;
  // parity of symbol index flip is inverted (flip < 0 disables).
  task automatic send_block(input logic [15:0] u, input int gap, input int flip,
                            input int nsym);
    logic [2:0] s;
    logic       fb;
    logic       p;
    s = 3'b000;
    for (int i = 0; i < nsym; i++) begin
      fb = u[i] ^ s[1] ^ s[0];
      p  = fb ^ s[2] ^ s[0];
      s  = {fb, s[2], s[1]};
      @(negedge clk);
      for (int w = 0; w < 100 && !in_ready; w++) @(negedge clk);
      if (i == 0 || gap > 0) check("in_ready_before_symbol", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      sys_bit  = u[i];
      par_bit  = p ^ (i == flip);
      @(posedge clk);
      if (i < nsym - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          sys_bit  = ~sys_bit;
          par_bit  = ~par_bit;
          @(posedge clk);
        end
      end
    end
  endtask

  // Called right after the last accepting edge; negedge i is in cycle T+i.
  task automatic collect(input string tag, input logic [15:0] exp_blk,
                         input logic [7:0] exp_met);
    int          lat = -1;
    int          rdy_low = 0;
    bit          rdy_back = 1'b0;
    logic [15:0] blk = 'x;
    logic [7:0]  met = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (!rdy_back) begin
        if (!in_ready) rdy_low++;
        else rdy_back = 1'b1;
      end
      if (out_valid && lat < 0) begin
        lat = i;
        blk = out_block;
        met = out_metric;
      end
      if (lat > 0 && rdy_back) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check({tag, "_ready_low"}, 32'(rdy_low), 32'd18);
    check({tag, "_block"}, 32'(blk), 32'(exp_blk));
    check({tag, "_metric"}, 32'(met), 32'(exp_met));
    check({tag, "_pulse_one_cycle"}, 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_hold_block"}, 32'(out_block), 32'(exp_blk));
    check({tag, "_hold_metric"}, 32'(out_metric), 32'(exp_met));
  endtask

  initial begin
    logic [15:0] u;
    bit          saw;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_block", 32'(out_block), 32'd0);
    check("rst_out_metric", 32'(out_metric), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // All-zero block
    send_block(16'h0000, 0, -1, 16);
    collect("zeros", 16'h0000, 8'd0);

    // Single leading one: pairs (1,1),(0,1),(0,1)...
    send_block(16'h0001, 0, -1, 16);
    collect("impulse", 16'h0001, 8'd1 - 8'd1);

    // Same with parity of symbol 5 inverted: corrected, distance 1
    send_block(16'h0001, 0, 5, 16);
    collect("impulse_err", 16'h0001, 8'd1);

    // Mixed pattern, gap-free then with 3 idle cycles between symbols
    send_block(16'hC35A, 0, -1, 16);
    collect("mixed", 16'hC35A, 8'd0);
    send_block(16'hC35A, 3, -1, 16);
    collect("mixed_gap", 16'hC35A, 8'd0);

    // Patterns ending in ones exercise the tail of the traceback
    send_block(16'hFFFF, 0, -1, 16);
    collect("ones", 16'hFFFF, 8'd0);
    send_block(16'h8000, 0, -1, 16);
    collect("msb", 16'h8000, 8'd0);

    // Random error-free blocks
    for (int b = 0; b < 100; b++) begin
      u = 16'($urandom);
      send_block(u, 0, -1, 16);
      collect("random", u, 8'd0);
    end

    // Reset during TRACE: no pulse for the aborted block, outputs cleared
    send_block(16'hBEEF, 0, -1, 16);
    saw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      saw |= out_valid;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_trace_ready_in_rst", 32'(in_ready), 32'd0);
    check("abort_trace_block_cleared", 32'(out_block), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw |= out_valid;
    end
    check("abort_trace_no_pulse", 32'(saw), 32'd0);
    send_block(16'h0000, 0, -1, 16);
    collect("after_abort_trace", 16'h0000, 8'd0);

    // Reset mid-ACS: the following block must start from a fresh trellis
    send_block(16'h00FF, 0, -1, 5);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_block(16'hA5C3, 0, -1, 16);
    collect("after_abort_acs", 16'hA5C3, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
